// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame FSM states and Mux4x1 select codes.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Select codes driven into the registered 4:1 line mux
    localparam logic [1:0] MUX_SEL_START = 2'b00;
    localparam logic [1:0] MUX_SEL_IDLE  = 2'b01;
    localparam logic [1:0] MUX_SEL_DATA  = 2'b10;
    localparam logic [1:0] MUX_SEL_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register plus bit counter; bit 0 is the current serial bit.
// ser_done_o flags the last data bit (counter == DATA_WIDTH-1); counter never wraps past it.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ser_bit_o,
    output logic                  ser_done_o
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_bit_o  = shreg_q[0];
    assign ser_done_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: start, LSB-first data, optional parity, stop; Moore outputs for Mux4x1.
// Define UART_TX_BACK2BACK_EN to accept a new word during STOP (zero idle cycles between frames).
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  SER_Data,
    output logic                  PAR_Bit,
    output logic [1:0]            Mux_Sel,
    output logic                  Busy
);
    tx_state_e  state_q;
    logic [1:0] mux_sel_q;
    logic       busy_q;
    logic       par_bit_q;
    logic       par_en_q;
    logic       accept;
    logic       shift;
    logic       ser_done;

`ifdef UART_TX_BACK2BACK_EN
    assign accept = Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));
`else
    assign accept = Data_Valid && (state_q == ST_IDLE);
`endif

    // The last data bit is held rather than shifted so the counter stops at DATA_WIDTH-1
    assign shift = (state_q == ST_DATA) && !ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (accept),
        .shift_i    (shift),
        .data_i     (P_DATA),
        .ser_bit_o  (SER_Data),
        .ser_done_o (ser_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            mux_sel_q <= MUX_SEL_IDLE;
            busy_q    <= 1'b0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else if (accept) begin
            state_q   <= ST_START;
            mux_sel_q <= MUX_SEL_START;
            busy_q    <= 1'b1;
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
        end else begin
            case (state_q)
                ST_START: begin
                    state_q   <= ST_DATA;
                    mux_sel_q <= MUX_SEL_DATA;
                    busy_q    <= 1'b1;
                end
                ST_DATA: begin
                    busy_q <= 1'b1;
                    if (ser_done) begin
                        if (par_en_q) begin
                            state_q   <= ST_PARITY;
                            mux_sel_q <= MUX_SEL_PAR;
                        end else begin
                            state_q   <= ST_STOP;
                            mux_sel_q <= MUX_SEL_IDLE;
                        end
                    end
                end
                ST_PARITY: begin
                    state_q   <= ST_STOP;
                    mux_sel_q <= MUX_SEL_IDLE;
                    busy_q    <= 1'b1;
                end
                ST_STOP: begin
                    state_q   <= ST_IDLE;
                    mux_sel_q <= MUX_SEL_IDLE;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mux_sel_q <= MUX_SEL_IDLE;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign Mux_Sel = mux_sel_q;
    assign Busy    = busy_q;
    assign PAR_Bit = par_bit_q;

endmodule
